// File: rtl/mem_arbiter_if.sv
// Bundle of the controlpath request/response signals and the memory bus seen by mem_arbiter.
//   master : the arbiter side (takes requests and memory responses, drives the results and the bus)
//   slave  : the environment side (controlpath plus memory model)
// Controlpath: instr_req/instr_addr, ld/st/data_addr/data_wdata in;
//              instruction/wait_instr/instr_segv, data_rdata/wait_data/data_segv out.
// Memory:      mem_req/mem_we/mem_addr/mem_wdata out; mem_rdata/mem_ack in.
interface mem_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        ld;
  logic        st;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] instruction;
  logic        wait_instr;
  logic        instr_segv;
  logic [31:0] data_rdata;
  logic        wait_data;
  logic        data_segv;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  instr_req, instr_addr, ld, st, data_addr, data_wdata, mem_rdata, mem_ack,
    output instruction, wait_instr, instr_segv, data_rdata, wait_data, data_segv,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output instr_req, instr_addr, ld, st, data_addr, data_wdata, mem_rdata, mem_ack,
    input  instruction, wait_instr, instr_segv, data_rdata, wait_data, data_segv,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// Data requests win over fetches. Accesses are checked for alignment, range and ROM writes
// at grant; a bad access skips the memory and reports a one-cycle segv in RESP. A memory
// access that is not acked within TIMEOUT busy cycles is also reported as a fault.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mem_arbiter_if.master (controlpath requests/results and memory bus)
module mem_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0001_0000,
  parameter logic [31:0] ROM_LIMIT  = 32'h0000_1000,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic           clk,
  input logic           reset_n,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
  typedef enum logic {OwnInstr, OwnData} owner_e;

  // Counter value in the last permitted busy cycle.
  localparam logic [3:0] CntLast = 4'(TIMEOUT - 1);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        fault_q, fault_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] drd_q, drd_d;

  logic data_req;
  logic data_fault;
  logic instr_fault;

  assign data_req    = bus.ld | bus.st;
  assign data_fault  = (bus.data_addr[1:0] != 2'b00) || (bus.data_addr >= ADDR_LIMIT) ||
                       (bus.st && (bus.data_addr < ROM_LIMIT)) || (bus.ld && bus.st);
  assign instr_fault = (bus.instr_addr[1:0] != 2'b00) || (bus.instr_addr >= ADDR_LIMIT);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    instr_d     = instr_q;
    drd_d       = drd_q;

    unique case (state_q)
      StIdle: begin
        if (data_req) begin
          owner_d = OwnData;
          fault_d = data_fault;
          if (data_fault) begin
            state_d = StResp;
          end else begin
            state_d     = StBusy;
            mem_addr_d  = bus.data_addr;
            mem_we_d    = bus.st;
            mem_wdata_d = bus.st ? bus.data_wdata : 32'h0;
          end
        end else if (bus.instr_req) begin
          owner_d = OwnInstr;
          fault_d = instr_fault;
          if (instr_fault) begin
            state_d = StResp;
          end else begin
            state_d     = StBusy;
            mem_addr_d  = bus.instr_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = 32'h0;
          end
        end
      end
      StBusy: begin
        // Ack in the final permitted cycle still counts as success.
        if (bus.mem_ack) begin
          state_d = StResp;
          fault_d = 1'b0;
          cnt_d   = 4'd0;
          if (owner_q == OwnInstr) begin
            instr_d = bus.mem_rdata;
          end else if (!mem_we_q) begin
            drd_d = bus.mem_rdata;
          end
        end else if (cnt_q == CntLast) begin
          state_d = StResp;
          fault_d = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      owner_q     <= OwnInstr;
      fault_q     <= 1'b0;
      cnt_q       <= 4'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      instr_q     <= 32'h0;
      drd_q       <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      instr_q     <= instr_d;
      drd_q       <= drd_d;
    end
  end

  logic resp_instr;
  logic resp_data;

  assign resp_instr = (state_q == StResp) && (owner_q == OwnInstr);
  assign resp_data  = (state_q == StResp) && (owner_q == OwnData);

  assign bus.mem_req     = (state_q == StBusy);
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.instruction = instr_q;
  assign bus.data_rdata  = drd_q;
  assign bus.instr_segv  = resp_instr && fault_q;
  assign bus.data_segv   = resp_data && fault_q;
  assign bus.wait_instr  = bus.instr_req && !resp_instr;
  assign bus.wait_data   = data_req && !resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a table of single transactions with
// hand-computed results, then hand-written contention, timeout and mid-access reset sequences.
module tb_mem_arbiter;

  localparam int KFetch = 0;
  localparam int KLd    = 1;
  localparam int KSt    = 2;
  localparam int KLdSt  = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;      // busy cycles before the ack cycle
    logic [31:0] rdata;
    logic        exp_fault;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  logic [31:0] exp_instr;
  logic [31:0] exp_drd;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.instr_req  = 1'b0;
    bus.instr_addr = 32'h0;
    bus.ld         = 1'b0;
    bus.st         = 1'b0;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " mem_req"}, {31'h0, bus.mem_req}, 32'h0);
    chk({tag, " mem_we"}, {31'h0, bus.mem_we}, 32'h0);
    chk({tag, " mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, " mem_wdata"}, bus.mem_wdata, 32'h0);
    chk({tag, " instruction"}, bus.instruction, 32'h0);
    chk({tag, " data_rdata"}, bus.data_rdata, 32'h0);
    chk({tag, " instr_segv"}, {31'h0, bus.instr_segv}, 32'h0);
    chk({tag, " data_segv"}, {31'h0, bus.data_segv}, 32'h0);
  endtask

  // Called at posedge+1 with the FSM idle; returns one cycle after RESP, idle again.
  task automatic run_vec(input vec_t v);
    logic is_instr;
    logic wt;
    logic sg;
    logic sg_other;
    is_instr       = (v.kind == KFetch);
    bus.instr_req  = is_instr;
    bus.ld         = (v.kind == KLd) || (v.kind == KLdSt);
    bus.st         = (v.kind == KSt) || (v.kind == KLdSt);
    bus.instr_addr = is_instr ? v.addr : 32'h0;
    bus.data_addr  = is_instr ? 32'h0 : v.addr;
    bus.data_wdata = v.wdata;
    #1;
    wt = is_instr ? bus.wait_instr : bus.wait_data;
    chk({v.name, " wait before grant"}, {31'h0, wt}, 32'h1);
    step();
    if (v.exp_fault) begin
      sg       = is_instr ? bus.instr_segv : bus.data_segv;
      sg_other = is_instr ? bus.data_segv : bus.instr_segv;
      wt       = is_instr ? bus.wait_instr : bus.wait_data;
      chk({v.name, " segv"}, {31'h0, sg}, 32'h1);
      chk({v.name, " other segv"}, {31'h0, sg_other}, 32'h0);
      chk({v.name, " mem_req on fault"}, {31'h0, bus.mem_req}, 32'h0);
      chk({v.name, " wait in resp"}, {31'h0, wt}, 32'h0);
      chk({v.name, " instruction kept"}, bus.instruction, exp_instr);
      chk({v.name, " data_rdata kept"}, bus.data_rdata, exp_drd);
    end else begin
      chk({v.name, " mem_req"}, {31'h0, bus.mem_req}, 32'h1);
      chk({v.name, " mem_addr"}, bus.mem_addr, v.addr);
      chk({v.name, " mem_we"}, {31'h0, bus.mem_we}, {31'h0, v.exp_we});
      chk({v.name, " mem_wdata"}, bus.mem_wdata, v.exp_wdata);
      // Addresses moving during the access must not disturb it.
      bus.instr_addr = 32'hFFFF_FFF0;
      bus.data_addr  = 32'hFFFF_FFF0;
      for (int i = 0; i < v.delay; i++) begin
        step();
        chk({v.name, " mem_req held"}, {31'h0, bus.mem_req}, 32'h1);
        chk({v.name, " mem_addr held"}, bus.mem_addr, v.addr);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = v.rdata;
      step();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      if (v.kind == KFetch) exp_instr = v.rdata;
      if (v.kind == KLd) exp_drd = v.rdata;
      wt = is_instr ? bus.wait_instr : bus.wait_data;
      sg = is_instr ? bus.instr_segv : bus.data_segv;
      chk({v.name, " mem_req in resp"}, {31'h0, bus.mem_req}, 32'h0);
      chk({v.name, " wait in resp"}, {31'h0, wt}, 32'h0);
      chk({v.name, " segv in resp"}, {31'h0, sg}, 32'h0);
      chk({v.name, " instruction"}, bus.instruction, exp_instr);
      chk({v.name, " data_rdata"}, bus.data_rdata, exp_drd);
    end
    clear_inputs();
    step();
    chk({v.name, " idle after resp"}, {31'h0, bus.mem_req}, 32'h0);
  endtask

  vec_t vecs[13];

  initial begin
    int n;
    n_checks  = 0;
    n_fail    = 0;
    exp_instr = 32'h0;
    exp_drd   = 32'h0;

    //         name          kind    addr          wdata         dly rdata        flt we wdata
    vecs[0]  = '{"fetch",    KFetch, 32'h0000_1004, 32'h0,        1, 32'h8080_1234, 0, 0, 32'h0};
    vecs[1]  = '{"ld",       KLd,    32'h0000_2000, 32'hAAAA_0000, 0, 32'hDEAD_BEEF, 0, 0, 32'h0};
    vecs[2]  = '{"st",       KSt,    32'h0000_3000, 32'h1234_5678, 2, 32'h9999_9999, 0, 1,
                 32'h1234_5678};
    vecs[3]  = '{"st rom",   KSt,    32'h0000_0800, 32'h1,        0, 32'h0,         1, 0, 32'h0};
    vecs[4]  = '{"fetch mis", KFetch, 32'h0000_2002, 32'h0,       0, 32'h0,         1, 0, 32'h0};
    vecs[5]  = '{"ld+st",    KLdSt,  32'h0000_2000, 32'h0,        0, 32'h0,         1, 0, 32'h0};
    vecs[6]  = '{"ld limit", KLd,    32'h0001_0000, 32'h0,        0, 32'h0,         1, 0, 32'h0};
    vecs[7]  = '{"ld top",   KLd,    32'h0000_FFFC, 32'h0,        3, 32'h0BAD_F00D, 0, 0, 32'h0};
    vecs[8]  = '{"st romlim", KSt,   32'h0000_1000, 32'hCAFE_F00D, 0, 32'h7777_7777, 0, 1,
                 32'hCAFE_F00D};
    vecs[9]  = '{"ld rom",   KLd,    32'h0000_0000, 32'h0,        1, 32'h55AA_55AA, 0, 0, 32'h0};
    vecs[10] = '{"fetch odd", KFetch, 32'h0000_0001, 32'h0,       0, 32'h0,         1, 0, 32'h0};
    vecs[11] = '{"fetch far", KFetch, 32'h0002_0000, 32'h0,       0, 32'h0,         1, 0, 32'h0};
    vecs[12] = '{"fetch top", KFetch, 32'h0000_FFFC, 32'h0,       0, 32'h1357_9BDF, 0, 0, 32'h0};

    clear_inputs();
    reset_n = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    chk("reset wait_instr", {31'h0, bus.wait_instr}, 32'h0);
    chk("reset wait_data", {31'h0, bus.wait_data}, 32'h0);
    reset_n = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Timeout: legal load never acked.
    bus.ld        = 1'b1;
    bus.data_addr = 32'h0000_2000;
    step();
    n = 0;
    while (bus.mem_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("timeout busy cycles", n, 15);
    chk("timeout data_segv", {31'h0, bus.data_segv}, 32'h1);
    chk("timeout wait_data", {31'h0, bus.wait_data}, 32'h0);
    chk("timeout data_rdata kept", bus.data_rdata, exp_drd);
    bus.ld        = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    step();
    bus.mem_ack = 1'b0;
    chk("late ack mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("late ack data_rdata", bus.data_rdata, exp_drd);
    chk("late ack data_segv", {31'h0, bus.data_segv}, 32'h0);
    clear_inputs();
    step();

    // Contention: data goes first, fetch follows after the data RESP.
    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h0000_1004;
    bus.ld         = 1'b1;
    bus.data_addr  = 32'h0000_2000;
    step();
    chk("contend data addr", bus.mem_addr, 32'h0000_2000);
    chk("contend data we", {31'h0, bus.mem_we}, 32'h0);
    chk("contend wait_instr busy", {31'h0, bus.wait_instr}, 32'h1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    step();
    bus.mem_ack = 1'b0;
    exp_drd     = 32'h1111_2222;
    chk("contend data_rdata", bus.data_rdata, exp_drd);
    chk("contend wait_data resp", {31'h0, bus.wait_data}, 32'h0);
    chk("contend wait_instr resp", {31'h0, bus.wait_instr}, 32'h1);
    bus.ld = 1'b0;
    step();
    chk("contend idle gap", {31'h0, bus.mem_req}, 32'h0);
    step();
    chk("contend fetch granted", {31'h0, bus.mem_req}, 32'h1);
    chk("contend fetch addr", bus.mem_addr, 32'h0000_1004);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h3333_4444;
    step();
    bus.mem_ack = 1'b0;
    exp_instr   = 32'h3333_4444;
    chk("contend instruction", bus.instruction, exp_instr);
    chk("contend wait_instr done", {31'h0, bus.wait_instr}, 32'h0);
    // instr_req left high: treated as a fresh request.
    step();
    chk("refetch idle", {31'h0, bus.mem_req}, 32'h0);
    step();
    chk("refetch granted", {31'h0, bus.mem_req}, 32'h1);

    // Reset in the middle of the access.
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid-busy reset");
    chk("mid-busy reset wait_instr", {31'h0, bus.wait_instr}, 32'h1);
    bus.instr_req = 1'b0;
    exp_instr     = 32'h0;
    exp_drd       = 32'h0;
    step();
    step();
    reset_n       = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hEEEE_EEEE;
    step();
    bus.mem_ack = 1'b0;
    chk("stray ack mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("stray ack instruction", bus.instruction, 32'h0);
    step();
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'h0001_0000: byte addresses >= this value are out of range.
REQ-002 Parameter ROM_LIMIT, default 32'h0000_1000: byte addresses below this value are read-only.
REQ-003 Parameter TIMEOUT, default 15: maximum number of BUSY cycles allowed before mem_ack.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 instr_req  in  1  instruction fetch request from controlpath.
REQ-007 instr_addr  in  32  fetch byte address.
REQ-008 ld  in  1  data load request.
REQ-009 st  in  1  data store request.
REQ-010 data_addr  in  32  load/store byte address.
REQ-011 data_wdata  in  32  store data.
REQ-012 mem_rdata  in  32  memory read data, valid with mem_ack.
REQ-013 mem_ack  in  1  memory completion strobe.
REQ-014 instruction  out  32  fetched word.
REQ-015 wait_instr  out  1  fetch pending, not complete.
REQ-016 instr_segv  out  1  fetch fault.
REQ-017 data_rdata  out  32  loaded word.
REQ-018 wait_data  out  1  load/store pending, not complete.
REQ-019 data_segv  out  1  load/store fault.
REQ-020 mem_req, mem_we  out  1 each  memory access strobe and write enable.
REQ-021 mem_addr, mem_wdata  out  32 each  memory address and write data.

Function
REQ-022 The FSM SHALL have states IDLE, BUSY, RESP; an owner flag (INSTR/DATA) SHALL record the granted requester.
REQ-023 In IDLE, if ld or st is high, the data port SHALL be granted; otherwise, if instr_req is high, the instruction port SHALL be granted (data priority).
REQ-024 At grant, a request SHALL fault when: addr[1:0] != 0; addr >= ADDR_LIMIT; st with addr < ROM_LIMIT; or ld and st both high.
REQ-025 A faulting grant SHALL go IDLE->RESP directly, with mem_req never asserted.
REQ-026 A legal grant SHALL go IDLE->BUSY, registering mem_addr, mem_we (st), and mem_wdata (data_wdata on st, else 0).
REQ-027 mem_req SHALL be 1 exactly while in BUSY.
REQ-028 In BUSY, a 4-bit counter SHALL increment each cycle without mem_ack.
REQ-029 mem_ack in BUSY SHALL go to RESP, capturing mem_rdata into instruction or data_rdata per owner; a store SHALL leave data_rdata unchanged.
REQ-030 When the counter reaches TIMEOUT without mem_ack, the FSM SHALL go to RESP as a fault; any later mem_ack SHALL be ignored.
REQ-031 RESP SHALL last exactly one cycle, then return to IDLE; the counter SHALL clear on leaving BUSY.
REQ-032 instr_segv / data_segv SHALL be 1 only during RESP of a faulting access for that owner.
REQ-033 wait_instr SHALL equal instr_req AND NOT (state==RESP AND owner==INSTR).
REQ-034 wait_data SHALL equal (ld OR st) AND NOT (state==RESP AND owner==DATA).
REQ-035 Both wait outputs SHALL be combinational from registered state and the request inputs.
REQ-036 A request still high in IDLE after its RESP SHALL be treated as a new request.
REQ-037 Request inputs changing during BUSY SHALL NOT alter the access in flight.
REQ-038 Fetch latency SHALL be 1 cycle plus the memory ack latency: request seen at edge N -> mem_req high in cycle N+1 -> RESP the cycle after the ack edge.

Reset
REQ-039 reset_n low SHALL immediately force IDLE, owner INSTR, counter 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, instruction 0, data_rdata 0, instr_segv 0, data_segv 0.
REQ-040 Reset during BUSY SHALL abandon the access; a mem_ack arriving after reset release with the FSM in IDLE SHALL be ignored.

Verification
REQ-041 Fetch: instr_req=1, instr_addr=32'h0000_1004, mem_ack one cycle after mem_req with mem_rdata=32'h8080_1234 -> wait_instr=1 until RESP; in RESP, instruction=32'h8080_1234, wait_instr=0, instr_segv=0.
REQ-042 Contention: instr_req=1 and ld=1 in the same IDLE cycle -> data access served first (mem_we=0); fetch granted in the IDLE cycle after its RESP.
REQ-043 Faults: st to 32'h0000_0800 -> data_segv=1 in RESP, mem_req never 1; instr_addr=32'h0000_2002 -> instr_segv=1; ld=st=1 -> data_segv=1.
REQ-044 Timeout: legal ld, mem_ack held 0 -> mem_req=1 for exactly 15 cycles, then RESP with data_segv=1; a late mem_ack is ignored.
REQ-045 Reset mid-BUSY: reset_n=0 while mem_req=1 -> mem_req=0 immediately and all outputs at reset values; normal fetch succeeds after release.
